// File: rtl/keypad_scanner.sv
// N_LIN x N_COL matrix keypad scanner: one-cold column strobes, debounced press/release, row-major key code.
// Optional auto-repeat of key_valid while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned N_LIN          = 4,
  parameter int unsigned N_COL          = 4,
  parameter int unsigned SCAN_CYCLES    = 300,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_DELAY   = 32,
  parameter int unsigned REPEAT_RATE    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_LIN-1:0]                   linhas,
  output logic [N_COL-1:0]                   colunas,
  output logic [$clog2(N_LIN*N_COL+1)-1:0]   key_code,
  output logic                               key_valid,
  output logic                               key_held,
  output logic [$clog2(N_COL)-1:0]           col_idx
);

  localparam int unsigned KW = $clog2(N_LIN * N_COL + 1);
  localparam int unsigned CW = $clog2(N_COL);
  localparam int unsigned RW = (N_LIN > 1) ? $clog2(N_LIN) : 1;
  localparam int unsigned DW = $clog2(SCAN_CYCLES);
  localparam int unsigned NW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [KW-1:0] K_NULL = '1;

  if (N_LIN == 0 || N_COL < 2 || SCAN_CYCLES < 2 || DEBOUNCE_SCANS == 0 ||
      REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_params
    $error("keypad_scanner: illegal parameter set");
  end

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED} state_t;

  state_t          state;
  logic [DW-1:0]   dwell;
  logic [NW-1:0]   deb;
  logic [RW-1:0]   lat_row;
  logic [CW-1:0]   lat_col;
  logic [RW-1:0]   low_row;
  logic            low_any;
  logic            sample;
  logic            row_hi;
  logic [CW-1:0]   col_nxt;
  logic            enter_press;
  logic            release_now;
  logic            advance;
  logic [KW-1:0]   press_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned PW      = $clog2(REP_MAX + 1);
  logic [PW-1:0] rep_cnt;
  logic          rep_first;
`endif

  function automatic logic [KW-1:0] code_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return KW'(KW'(r) * KW'(N_COL) + KW'(c));
  endfunction

  // Lowest-index active (low) row in the currently driven column.
  always_comb begin
    low_any = 1'b0;
    low_row = '0;
    for (int i = N_LIN - 1; i >= 0; i--) begin
      if (!linhas[i]) begin
        low_any = 1'b1;
        low_row = RW'(i);
      end
    end
  end

  assign sample      = (dwell == DW'(SCAN_CYCLES - 1));
  assign row_hi      = linhas[lat_row];
  assign col_nxt     = (col_idx == CW'(N_COL - 1)) ? '0 : col_idx + CW'(1);
  assign press_code  = (state == ST_SCAN) ? code_of(low_row, col_idx) : code_of(lat_row, lat_col);
  assign enter_press = sample &&
                       (((state == ST_SCAN) && low_any && (DEBOUNCE_SCANS == 1)) ||
                        ((state == ST_DEBOUNCE) && !row_hi && (deb == NW'(DEBOUNCE_SCANS - 1))));
  assign release_now = sample && (state == ST_PRESSED) && row_hi && (deb == NW'(DEBOUNCE_SCANS - 1));
  assign advance     = sample &&
                       (((state == ST_SCAN) && !low_any) ||
                        ((state == ST_DEBOUNCE) && row_hi) ||
                        release_now);

  // Scan/debounce/press FSM; all outputs registered. Later assignments override the case defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      dwell     <= '0;
      deb       <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      col_idx   <= '0;
      colunas   <= ~N_COL'(1);
      key_code  <= K_NULL;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      dwell     <= sample ? '0 : dwell + DW'(1);
      if (sample) begin
        unique case (state)
          ST_SCAN: begin
            if (low_any) begin
              lat_row <= low_row;
              lat_col <= col_idx;
              deb     <= NW'(1);
              state   <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (row_hi) state <= ST_SCAN;
            else        deb   <= deb + NW'(1);
          end
          ST_PRESSED: begin
            if (row_hi) deb <= deb + NW'(1);
            else        deb <= '0;
`ifdef KEYPAD_REPEAT_EN
            if (row_hi) begin
              rep_cnt   <= '0;
              rep_first <= 1'b1;
            end else if (rep_cnt + PW'(1) == (rep_first ? PW'(REPEAT_DELAY) : PW'(REPEAT_RATE))) begin
              key_valid <= 1'b1;
              rep_cnt   <= '0;
              rep_first <= 1'b0;
            end else begin
              rep_cnt <= rep_cnt + PW'(1);
            end
`endif
          end
          default: state <= ST_SCAN;
        endcase

        if (enter_press) begin
          state     <= ST_PRESSED;
          deb       <= '0;
          key_code  <= press_code;
          key_held  <= 1'b1;
          key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt   <= '0;
          rep_first <= 1'b1;
`endif
        end

        if (release_now) begin
          state    <= ST_SCAN;
          deb      <= '0;
          key_code <= K_NULL;
          key_held <= 1'b0;
        end

        if (advance) begin
          col_idx <= col_nxt;
          colunas <= ~(N_COL'(1) << col_nxt);
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a modelled 4x4 key matrix (SCAN_CYCLES=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;

`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_PRESS_STROBES = 10;
`else
  localparam int EXP_PRESS_STROBES = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       linhas;
  logic [3:0]       colunas;
  logic [4:0]       key_code;
  logic             key_valid;
  logic             key_held;
  logic [1:0]       col_idx;
  logic [3:0][3:0]  keys;

  int n_cmp = 0;
  int n_bad = 0;
  int tk    = 0;

  keypad_scanner #(
    .N_LIN(4), .N_COL(4), .SCAN_CYCLES(4), .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .linhas(linhas), .colunas(colunas),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .col_idx(col_idx)
  );

  always #5 clk = ~clk;

  // Row r reads low when a closed key in row r sits on the column driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) linhas[r] = ~|(keys[r] & ~colunas);
  end

  task automatic step();
    @(negedge clk);
    tk++;
  endtask

  task automatic run(input int n, output int strobes, output int first);
    strobes = 0;
    first   = -1;
    for (int i = 0; i < n; i++) begin
      step();
      if (key_valid === 1'b1) begin
        strobes++;
        if (first < 0) first = tk;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_col;
    one  = 4'b0001;
    keys = '0;
    rst  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tk  = 0;
    n_cmp++; if (colunas !== 4'b1110) begin n_bad++; $display("FAIL reset_colunas: got %b want 1110", colunas); end
    n_cmp++; if (key_code !== 5'd31) begin n_bad++; $display("FAIL reset_key_code: got %0d want 31", key_code); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL reset_key_held: got %b want 0", key_held); end
    n_cmp++; if (col_idx !== 2'd0) begin n_bad++; $display("FAIL reset_col_idx: got %0d want 0", col_idx); end
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(one << ((tk / 4) % 4));
      n_cmp++; if (colunas !== exp_col) begin n_bad++; $display("FAIL idle_scan t=%0d: got %b want %b", tk, colunas, exp_col); end
      n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid t=%0d: got %b want 0", tk, key_valid); end
      step();
    end
  endtask

  task automatic test_press();
    int s, f;
    keys[1][2] = 1'b1;
    run(100, s, f);
    n_cmp++; if (s !== EXP_PRESS_STROBES) begin n_bad++; $display("FAIL press_strobes: got %0d want %0d", s, EXP_PRESS_STROBES); end
    n_cmp++; if (f !== 36) begin n_bad++; $display("FAIL press_latency: first strobe at %0d want 36", f); end
    n_cmp++; if (key_code !== 5'd6) begin n_bad++; $display("FAIL press_code: got %0d want 6", key_code); end
    n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL press_held: got %b want 1", key_held); end
    n_cmp++; if (colunas !== 4'b1011) begin n_bad++; $display("FAIL press_frozen: got %b want 1011", colunas); end
    n_cmp++; if (col_idx !== 2'd2) begin n_bad++; $display("FAIL press_col_idx: got %0d want 2", col_idx); end
  endtask

  task automatic test_release();
    int s, f;
    keys[1][2] = 1'b0;
    run(11, s, f);
    n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL release_early_held: got %b want 1", key_held); end
    n_cmp++; if (key_code !== 5'd6) begin n_bad++; $display("FAIL release_early_code: got %0d want 6", key_code); end
    step();
    if (key_valid === 1'b1) s++;
    n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL release_strobes: got %0d want 0", s); end
    n_cmp++; if (key_code !== 5'd31) begin n_bad++; $display("FAIL release_code: got %0d want 31", key_code); end
    n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL release_held: got %b want 0", key_held); end
    n_cmp++; if (col_idx !== 2'd3) begin n_bad++; $display("FAIL release_col_idx: got %0d want 3", col_idx); end
    n_cmp++; if (colunas !== 4'b0111) begin n_bad++; $display("FAIL release_colunas: got %b want 0111", colunas); end
  endtask

  task automatic test_bounce();
    int s, f, tot;
    run(4, s, f);
    tot = s;
    keys[2][0] = 1'b1;
    run(5, s, f);
    tot += s;
    n_cmp++; if (col_idx !== 2'd0) begin n_bad++; $display("FAIL bounce_frozen: got %0d want 0", col_idx); end
    step();
    if (key_valid === 1'b1) tot++;
    keys[2][0] = 1'b0;
    run(2, s, f);
    tot += s;
    n_cmp++; if (tot !== 0) begin n_bad++; $display("FAIL bounce_strobes: got %0d want 0", tot); end
    n_cmp++; if (key_code !== 5'd31) begin n_bad++; $display("FAIL bounce_code: got %0d want 31", key_code); end
    n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL bounce_held: got %b want 0", key_held); end
    n_cmp++; if (col_idx !== 2'd1) begin n_bad++; $display("FAIL bounce_resume: got %0d want 1", col_idx); end
  endtask

  task automatic test_simultaneous();
    int s, f;
    keys[0][1] = 1'b1;
    keys[3][1] = 1'b1;
    run(20, s, f);
    n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL simul_strobes: got %0d want 1", s); end
    n_cmp++; if (f !== 152) begin n_bad++; $display("FAIL simul_latency: first strobe at %0d want 152", f); end
    n_cmp++; if (key_code !== 5'd1) begin n_bad++; $display("FAIL simul_code: got %0d want 1", key_code); end
    keys[0][1] = 1'b0;
    run(12, s, f);
    n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL simul_release_strobes: got %0d want 0", s); end
    n_cmp++; if (key_code !== 5'd31) begin n_bad++; $display("FAIL simul_release_code: got %0d want 31", key_code); end
    n_cmp++; if (col_idx !== 2'd2) begin n_bad++; $display("FAIL simul_release_col: got %0d want 2", col_idx); end
    run(28, s, f);
    n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL second_strobes: got %0d want 1", s); end
    n_cmp++; if (f !== 196) begin n_bad++; $display("FAIL second_latency: first strobe at %0d want 196", f); end
    n_cmp++; if (key_code !== 5'd13) begin n_bad++; $display("FAIL second_code: got %0d want 13", key_code); end
    n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL second_held: got %b want 1", key_held); end
  endtask

  task automatic test_reset_pressed();
    int s, f;
    rst = 1'b1;
    step();
    n_cmp++; if (key_code !== 5'd31) begin n_bad++; $display("FAIL rstmid_code: got %0d want 31", key_code); end
    n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL rstmid_held: got %b want 0", key_held); end
    n_cmp++; if (col_idx !== 2'd0) begin n_bad++; $display("FAIL rstmid_col_idx: got %0d want 0", col_idx); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", key_valid); end
    n_cmp++; if (colunas !== 4'b1110) begin n_bad++; $display("FAIL rstmid_colunas: got %b want 1110", colunas); end
    keys = '0;
    rst  = 1'b0;
    run(20, s, f);
    n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL rstmid_strobes: got %0d want 0", s); end
  endtask

  initial begin
    rst  = 1'b1;
    keys = '0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_pressed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
